// File: rtl/psg_env_vca_mix.sv
// Envelope VCA and 4-channel voice mixer: one mixed sample per prescaler frame.
// Optional output clamp to the voice sample range when PSG_MIX_SAT_EN is defined.
module psg_env_vca_mix #(
    parameter int unsigned pChannels      = 4,
    parameter int unsigned pPrescalerBits = 5,
    parameter int unsigned pSampleBits    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [pPrescalerBits-1:0]       cnt,
    input  logic [7:0]                      env,
    input  logic signed [pSampleBits-1:0]   voice0,
    input  logic signed [pSampleBits-1:0]   voice1,
    input  logic signed [pSampleBits-1:0]   voice2,
    input  logic signed [pSampleBits-1:0]   voice3,
    output logic signed [pSampleBits+1:0]   o,
    output logic                            o_vld
);

    localparam int unsigned CH_BITS   = 2;
    localparam int unsigned ACC_BITS  = pSampleBits + 2;
    localparam int unsigned PROD_BITS = pSampleBits + 10;

    localparam logic [pPrescalerBits-1:0] CNT_MUL_FIRST = pPrescalerBits'(pChannels);
    localparam logic [pPrescalerBits-1:0] CNT_MUL_LAST  = pPrescalerBits'(2 * pChannels - 1);
    localparam logic [pPrescalerBits-1:0] CNT_ACC_FIRST = pPrescalerBits'(pChannels + 1);
    localparam logic [pPrescalerBits-1:0] CNT_ACC_LAST  = pPrescalerBits'(2 * pChannels);
    localparam logic [pPrescalerBits-1:0] CNT_PUB       = pPrescalerBits'(2 * pChannels + 1);

    localparam logic signed [ACC_BITS-1:0] SAT_MAX = {3'b000, {(pSampleBits-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN = {3'b111, {(pSampleBits-1){1'b0}}};

    logic [7:0]                   env_lat [pChannels];
    logic                         primed;
    logic signed [pSampleBits-1:0] prod;
    logic signed [ACC_BITS-1:0]   acc;

    logic                         capture_c;
    logic                         mul_c;
    logic                         acc_first_c;
    logic                         acc_more_c;
    logic                         pub_c;
    logic [CH_BITS-1:0]           mul_idx_c;
    logic [7:0]                   lvl_c;
    logic [8:0]                   gain_c;
    logic signed [pSampleBits-1:0] voice_sel_c;
    logic signed [PROD_BITS-1:0]  voice_ext_c;
    logic signed [PROD_BITS-1:0]  gain_ext_c;
    logic signed [PROD_BITS-1:0]  prod_full_c;
    logic signed [pSampleBits-1:0] prod_next_c;
    logic signed [ACC_BITS-1:0]   prod_ext_c;
    logic signed [ACC_BITS-1:0]   pub_val_c;
    logic                         unused_prod_bits_c;

    // Stage decode from the shared prescaler count.
    always_comb begin
        capture_c   = (cnt < CNT_MUL_FIRST);
        mul_c       = (cnt >= CNT_MUL_FIRST) && (cnt <= CNT_MUL_LAST);
        acc_first_c = (cnt == CNT_ACC_FIRST);
        acc_more_c  = (cnt > CNT_ACC_FIRST) && (cnt <= CNT_ACC_LAST);
        pub_c       = (cnt == CNT_PUB);
    end

    // Gain mapping 0..255 -> 0..256 so that 0xFF is exact unity, then scale the voice.
    always_comb begin
        mul_idx_c = CH_BITS'(cnt - CNT_MUL_FIRST);
        lvl_c     = env_lat[mul_idx_c];
        gain_c    = {1'b0, lvl_c} + 9'(lvl_c[7]);
        case (mul_idx_c)
            2'd0:    voice_sel_c = voice0;
            2'd1:    voice_sel_c = voice1;
            2'd2:    voice_sel_c = voice2;
            default: voice_sel_c = voice3;
        endcase
        voice_ext_c = PROD_BITS'(voice_sel_c);
        gain_ext_c  = PROD_BITS'(gain_c);
        prod_full_c = voice_ext_c * gain_ext_c;
        // Taking bits above the low 8 is an arithmetic shift that floors toward -inf.
        prod_next_c = prod_full_c[pSampleBits+7:8];
        prod_ext_c  = ACC_BITS'(prod);
        unused_prod_bits_c = &{1'b0, prod_full_c[7:0], prod_full_c[PROD_BITS-1:pSampleBits+8]};
    end

    // Publish value: full accumulator range, or clamped to the voice sample range.
    always_comb begin
        pub_val_c = acc;
`ifdef PSG_MIX_SAT_EN
        if (acc > SAT_MAX) begin
            pub_val_c = SAT_MAX;
        end else if (acc < SAT_MIN) begin
            pub_val_c = SAT_MIN;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(pChannels); i++) begin
                env_lat[i] <= 8'd0;
            end
            primed <= 1'b0;
            prod   <= '0;
            acc    <= '0;
            o      <= '0;
            o_vld  <= 1'b0;
        end else begin
            o_vld <= 1'b0;
            if (capture_c) begin
                env_lat[cnt[CH_BITS-1:0]] <= env;
                if (cnt == '0) begin
                    primed <= 1'b1;
                end
            end
            if (mul_c) begin
                prod <= prod_next_c;
            end
            if (acc_first_c) begin
                acc <= prod_ext_c;
            end else if (acc_more_c) begin
                acc <= acc + prod_ext_c;
            end
            // A frame only publishes once a full capture pass has been seen since reset.
            if (pub_c && primed) begin
                o     <= pub_val_c;
                o_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psg_env_vca_mix.sv
// Randomized bench for psg_env_vca_mix with a frame-level mixing model and literal pins.
module tb_psg_env_vca_mix;

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         cnt;
    logic [7:0]         env;
    logic signed [11:0] voice0, voice1, voice2, voice3;
    logic signed [13:0] o;
    logic               o_vld;

    int checks   = 0;
    int failures = 0;

`ifdef PSG_MIX_SAT_EN
    localparam int EXP_UNITY = 2047;
    localparam int EXP_NEGFS = -2048;
`else
    localparam int EXP_UNITY = 4096;
    localparam int EXP_NEGFS = -8192;
`endif

    psg_env_vca_mix dut (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt),
        .env    (env),
        .voice0 (voice0),
        .voice1 (voice1),
        .voice2 (voice2),
        .voice3 (voice3),
        .o      (o),
        .o_vld  (o_vld)
    );

    always #5 clk = ~clk;

    // Frame-level model: latched levels, per-channel scaled terms, published sum.
    int lvl [4];
    int term [4];
    bit primed_m  = 1'b0;
    int o_m       = 0;
    bit vld_m     = 1'b0;
    bit live      = 1'b0;
    bit saw_reset = 1'b0;

    function automatic int scale(input int v, input int level);
        int g;
        g = level + ((level >= 128) ? 1 : 0);
        return (v * g) >>> 8;
    endfunction

    function automatic int clamp_out(input int s);
`ifdef PSG_MIX_SAT_EN
        if (s > 2047) return 2047;
        if (s < -2048) return -2048;
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        int vk;
        live = 1'b1;
        if (rst) begin
            for (int i = 0; i < 4; i++) lvl[i] = 0;
            primed_m  = 1'b0;
            o_m       = 0;
            vld_m     = 1'b0;
            saw_reset = 1'b1;
        end else begin
            vld_m = 1'b0;
            if (cnt < 4) begin
                lvl[cnt] = int'(env);
                if (cnt == 0) primed_m = 1'b1;
            end
            if (cnt >= 4 && cnt < 8) begin
                case (cnt)
                    5'd4:    vk = voice0;
                    5'd5:    vk = voice1;
                    5'd6:    vk = voice2;
                    default: vk = voice3;
                endcase
                term[cnt - 4] = scale(vk, lvl[cnt - 4]);
            end
            if (cnt == 9 && primed_m) begin
                o_m   = clamp_out(term[0] + term[1] + term[2] + term[3]);
                vld_m = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model, plus strobe spacing in steady state.
    int cyc      = 0;
    int last_vld = -1;
    always @(negedge clk) begin
        if (live) begin
            cyc++;
            checks++;
            if (o_vld !== vld_m || o !== 14'(o_m)) begin
                failures++;
                $display("FAIL model cyc=%0d o=%0d exp=%0d o_vld=%0b exp=%0b",
                         cyc, o, o_m, o_vld, vld_m);
            end
            if (saw_reset) begin
                last_vld  = -1;
                saw_reset = 1'b0;
            end
            if (o_vld === 1'b1) begin
                if (last_vld >= 0) begin
                    checks++;
                    if (cyc - last_vld != 32) begin
                        failures++;
                        $display("FAIL spacing cyc=%0d gap=%0d exp=32", cyc, cyc - last_vld);
                    end
                end
                last_vld = cyc;
            end
        end
    end

    function automatic int pick_env();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h7F;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // One 32-count frame; optional reset window and literal check after the cnt==9 edge.
    task automatic run_frame(input int e[4], input int v[4], input int rst_from, input int rst_to,
                             input string name, input bit pin, input int pin_o, input bit pin_vld);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (pin && c == 10) begin
                checks++;
                if (o_vld !== pin_vld || int'(o) != pin_o) begin
                    failures++;
                    $display("FAIL %s o=%0d exp=%0d o_vld=%0b exp=%0b", name, o, pin_o, o_vld, pin_vld);
                end
            end
            cnt    = 5'(c);
            env    = (c < 4) ? 8'(e[c]) : 8'($urandom_range(0, 255));
            voice0 = 12'(v[0]);
            voice1 = 12'(v[1]);
            voice2 = 12'(v[2]);
            voice3 = 12'(v[3]);
            rst    = (c >= rst_from && c <= rst_to);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[4];
        int v[4];
        rst = 1'b1; cnt = 5'd31; env = 8'd0;
        voice0 = '0; voice1 = '0; voice2 = '0; voice3 = '0;

        run_frame('{255, 255, 255, 255}, '{1024, 1024, 1024, 1024}, 0, 2, "partial_frame", 1'b1, 0, 1'b0);
        run_frame('{255, 255, 255, 255}, '{1024, 1024, 1024, 1024}, -1, -1, "unity", 1'b1, EXP_UNITY, 1'b1);
        run_frame('{255, 255, 255, 255}, '{-2048, -2048, -2048, -2048}, -1, -1, "neg_full", 1'b1, EXP_NEGFS, 1'b1);
        run_frame('{128, 0, 0, 0}, '{1000, 777, -555, 2047}, -1, -1, "gain_80_pos", 1'b1, 503, 1'b1);
        run_frame('{128, 0, 0, 0}, '{-1000, 777, -555, 2047}, -1, -1, "gain_80_neg", 1'b1, -504, 1'b1);
        run_frame('{127, 0, 0, 0}, '{1000, -2048, 2047, 5}, -1, -1, "gain_7f", 1'b1, 496, 1'b1);
        run_frame('{0, 255, 0, 0}, '{500, -300, 700, 100}, -1, -1, "isolation", 1'b1, -300, 1'b1);
        run_frame('{255, 255, 255, 255}, '{1024, 1024, 1024, 1024}, 3, 3, "reset_mid", 1'b1, 0, 1'b0);
        run_frame('{255, 255, 255, 255}, '{1024, 1024, 1024, 1024}, -1, -1, "after_reset", 1'b1, EXP_UNITY, 1'b1);

        for (int f = 0; f < 43; f++) begin
            int r;
            for (int k = 0; k < 4; k++) begin
                e[k] = pick_env();
                v[k] = int'($urandom_range(0, 4095)) - 2048;
            end
            r = (f >= 3 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_frame(e, v, r, r, "random", 1'b0, 0, 1'b0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psg_env_vca_mix.md
# psg_env_vca_mix

Per-frame envelope consumer and voice mixer for the PSG. It samples the time-multiplexed envelope level that the envelope generator presents on each channel slot of the shared prescaler count. It scales each channel's signed voice sample by that level, sums the channels, and publishes one mixed sample per prescaler frame with a one-cycle valid strobe. It sits directly downstream of the envelope generator and shares its `cnt` prescaler.

## Interface
- `pChannels`, 4: number of voice channels. Fixed at 4 in this build.
- `pPrescalerBits`, 5: width of `cnt`. Must satisfy 2^pPrescalerBits ≥ 2·pChannels+2.
- `pSampleBits`, 12: width of the signed voice samples.
- `clk`, in, 1: core clock; single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `cnt`, in, pPrescalerBits: free-running prescaler count shared with the envelope generator.
- `env`, in, 8: envelope level for channel `cnt[1:0]`. Valid in the same cycle whenever `cnt < pChannels`.
- `voice0`..`voice3`, in, pSampleBits each: signed two's-complement voice samples. Each must be held stable through its multiply cycle.
- `o`, out, pSampleBits+2: signed mixed sample.
- `o_vld`, out, 1: single-cycle strobe marking a new `o`.

## Operation
The block runs in four stages per frame. C = pChannels. `cnt` wraps from 2^pPrescalerBits−1 to 0.

- **Capture** (`cnt` in 0..C−1): `env_lat[cnt] <= env`. At `cnt==0`, set `primed` to 1.
- **Multiply** (`cnt` in C..2C−1): with k = cnt−C, `prod <= (voice_k · gain_k) >>> 8`.
  - gain_k = env_lat[k] + env_lat[k][7], 9 bits unsigned, range 0..256. Level 0xFF gives exact unity; 0x80 gives 129.
  - The full product is 21-bit signed. The arithmetic shift floors toward −∞, leaving a pSampleBits-wide result.
- **Accumulate** (`cnt` in C+1..2C): at `cnt==C+1`, `acc <= sext(prod)`; on the remaining cycles, `acc <= acc + sext(prod)`.
  - `acc` is pSampleBits+2 bits signed. A 4-channel sum cannot overflow it.
- **Publish** (`cnt==2C+1`): if `primed`, `o <= acc` (or the saturated value, see Configuration) and `o_vld <= 1`. Otherwise `o` holds and `o_vld` stays 0.
- At all other counts, `o_vld <= 0`, and `acc`/`prod` hold.
- **Reset.** `o`, `o_vld`, `acc`, `prod`, all `env_lat` and `primed` all clear to 0.
  - Because `primed` is 0 after reset, a frame already in progress when reset deasserts never publishes.
  - The first `o_vld` occurs in the first frame that begins with `cnt==0` after reset.
- **Reset mid-operation.** `rst` wins over every stage in that cycle.
- **Channel activity.** Each channel's contribution is independent of whether that channel is active. A level of 0 contributes exactly 0.

## Timing
- Envelope is captured in the same cycle it is presented; there is no extra delay from `env` to `env_lat`.
- Voice k is sampled at the edge where `cnt==C+k`.
- With the defaults, `o`/`o_vld` update at the edge where `cnt==9`. `o_vld` is high for exactly the one following cycle.
- Latency from the last voice sample to `o`: 2 clocks.
- `o` holds its value until the next publish.
- Throughput: one sample per 2^pPrescalerBits clocks.

## Configuration
- `PSG_MIX_SAT_EN` defined: at publish, `acc` is clamped to [−2^(pSampleBits−1), 2^(pSampleBits−1)−1] and sign-extended into `o`. Defaults: −2048..2047.
- `PSG_MIX_SAT_EN` undefined: `o` carries the full `acc` range, −8192..8191 with the defaults.

## Test plan
- **Unity gain.** All `env`=0xFF, all voices=1024 → `o`=4096, `o_vld` high one cycle after the `cnt==9` edge. With `PSG_MIX_SAT_EN` defined → `o`=2047.
- **Negative full scale.** All `env`=0xFF, all voices=−2048 → `o`=−8192. With `PSG_MIX_SAT_EN` defined → `o`=−2048.
- **Rounding / gain mapping.** `env0`=0x80, `voice0`=1000, other levels 0 → `o`=503.
  - `voice0`=−1000 → `o`=−504.
  - `env0`=0x7F, `voice0`=1000 → `o`=496.
- **Channel isolation.** `env`={0,0xFF,0,0}, voices={500,−300,700,100} → `o`=−300.
- **Reset mid-frame.** Assert `rst` for one cycle at `cnt==3` → no `o_vld` in that frame, `o` stays 0. The next frame publishes the correct sum.
- **Wrap and steady state.** Run 3 consecutive frames with changing `env` → exactly one `o_vld` per frame, at a 32-clock spacing, with each `o` matching a reference model.
